// File: rtl/dvbs2x_symb_rate_divider_pkg.sv
// -----------------------------------------------------------------------------
// dvbs2x_symb_rate_divider_pkg
// Shared constants for the DVB-S2X symbol-rate divider: rate tables, register
// word offsets, AVMM response codes and the selection clamp helper.
// No ports (package).
// -----------------------------------------------------------------------------
package dvbs2x_symb_rate_divider_pkg;

  // Common registers (ID, VERSION, DEVICE_STATE) occupy word offsets 0..2.
  localparam int unsigned AVMM_COMMON_NUM_REGS = 32'd3;
  localparam int unsigned NUM_RATES            = 32'd4;
  localparam int unsigned SEL_W                = 32'd2;
  localparam int unsigned CNT_W                = 32'd8;

  typedef int unsigned rate_table_t [NUM_RATES];

  localparam rate_table_t DIV_RATIOS_DEF     = '{32'd1, 32'd2, 32'd4, 32'd8};
  localparam rate_table_t SYMB_RATE_MSPS_DEF = '{32'd100, 32'd50, 32'd25, 32'd12};

  // Word offsets of the register map; the block-specific registers follow
  // directly after the common ones.
  typedef enum logic [12:0] {
    REG_ID           = 13'd0,
    REG_VERSION      = 13'd1,
    REG_DEVICE_STATE = 13'd2,
    SYMB_RATE_SEL    = 13'd3,
    SYMB_RATE        = 13'd4,
    TOTAL_REGS       = 13'd5
  } reg_offset_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Out-of-range selections saturate to the slowest rate.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [31:0] wdata);
    if (wdata >= NUM_RATES) begin
      clamp_sel = SEL_W'(NUM_RATES - 32'd1);
    end else begin
      clamp_sel = wdata[SEL_W-1:0];
    end
  endfunction

endpackage

// File: rtl/dvbs2x_symb_rate_divider_regs.sv
// -----------------------------------------------------------------------------
// dvbs2x_symb_rate_divider_regs
// Avalon-MM register block: common ID/VERSION/DEVICE_STATE registers, the
// SYMB_RATE_SEL control register and the read-only SYMB_RATE status.
// Ports:
//   clk, sreset_n          - clock, synchronous active-low reset
//   init_done              - DEVICE_STATE bit0
//   active_sel             - selection currently applied to the stream
//   sel                    - programmed SYMB_RATE_SEL value
//   avmm_*                 - Avalon-MM slave (byte addresses, 32-bit data)
// -----------------------------------------------------------------------------
module dvbs2x_symb_rate_divider_regs
  import dvbs2x_symb_rate_divider_pkg::*;
#(
  parameter int unsigned MODULE_ID      = 32'd10,
  parameter int unsigned MODULE_VERSION = 32'd1,
  parameter rate_table_t SYMB_RATE_MSPS = SYMB_RATE_MSPS_DEF
) (
  input  logic             clk,
  input  logic             sreset_n,
  input  logic             init_done,
  input  logic [SEL_W-1:0] active_sel,
  output logic [SEL_W-1:0] sel,
  input  logic [14:0]      avmm_address,
  input  logic             avmm_read,
  input  logic             avmm_write,
  input  logic [31:0]      avmm_writedata,
  input  logic [3:0]       avmm_byteenable,
  input  logic [10:0]      avmm_burstcount,
  output logic [31:0]      avmm_readdata,
  output logic             avmm_readdatavalid,
  output logic             avmm_writeresponsevalid,
  output logic [1:0]       avmm_response,
  output logic             avmm_waitrequest
);

  logic [SEL_W-1:0] sel_r;
  logic [10:0]      rd_left_r;
  logic [10:0]      wr_left_r;

  logic [12:0] word_s;
  logic [31:0] rd_data_s;
  logic        rd_err_s;
  logic        wr_err_s;
  logic        wr_sel_s;
  logic        rd_acc_s;
  logic        wr_acc_s;
  logic        bc_one_s;
  logic [10:0] bc_rest_s;
  logic [10:0] rd_left_next_s;
  logic [10:0] wr_left_next_s;

  assign sel = sel_r;

  // Address decode, handshake qualification and burst beat bookkeeping.
  always_comb begin
    word_s         = avmm_address[14:2];
    rd_data_s      = 32'd0;
    rd_err_s       = 1'b0;
    wr_err_s       = 1'b0;
    wr_sel_s       = 1'b0;
    // A misaligned byte address is treated as outside the map.
    if (avmm_address[1:0] != 2'b00) begin
      rd_err_s = 1'b1;
      wr_err_s = 1'b1;
    end else begin
      case (word_s)
        REG_ID:           rd_data_s = MODULE_ID;
        REG_VERSION:      rd_data_s = MODULE_VERSION;
        REG_DEVICE_STATE: rd_data_s = {31'd0, init_done};
        SYMB_RATE_SEL: begin
          rd_data_s = 32'(sel_r);
          wr_sel_s  = 1'b1;
        end
        SYMB_RATE:        rd_data_s = SYMB_RATE_MSPS[active_sel];
        default: begin
          rd_err_s = 1'b1;
          wr_err_s = 1'b1;
        end
      endcase
    end

    // Reads win if a master ever raises both strobes.
    rd_acc_s  = avmm_read && !avmm_waitrequest;
    wr_acc_s  = avmm_write && !avmm_waitrequest && !avmm_read;
    bc_one_s  = (avmm_burstcount == 11'd1);
    bc_rest_s = (avmm_burstcount == 11'd0) ? 11'd0 : (avmm_burstcount - 11'd1);

    // Remaining error beats of a rejected read burst.
    if (rd_acc_s && !bc_one_s) begin
      rd_left_next_s = bc_rest_s;
    end else if (rd_left_r != 11'd0) begin
      rd_left_next_s = rd_left_r - 11'd1;
    end else begin
      rd_left_next_s = rd_left_r;
    end

    // Remaining beats of a rejected write burst; burstcount is only
    // meaningful on the first beat.
    if (wr_acc_s) begin
      if (wr_left_r != 11'd0) begin
        wr_left_next_s = wr_left_r - 11'd1;
      end else if (!bc_one_s) begin
        wr_left_next_s = bc_rest_s;
      end else begin
        wr_left_next_s = 11'd0;
      end
    end else begin
      wr_left_next_s = wr_left_r;
    end
  end

  // Register state and registered AVMM responses.
  always_ff @(posedge clk) begin
    if (!sreset_n) begin
      sel_r                   <= {SEL_W{1'b0}};
      rd_left_r               <= 11'd0;
      wr_left_r               <= 11'd0;
      avmm_readdata           <= 32'd0;
      avmm_readdatavalid      <= 1'b0;
      avmm_writeresponsevalid <= 1'b0;
      avmm_response           <= RESP_OKAY;
      avmm_waitrequest        <= 1'b1;
    end else begin
      rd_left_r               <= rd_left_next_s;
      wr_left_r               <= wr_left_next_s;
      // Stall new commands while read-burst error beats are still draining.
      avmm_waitrequest        <= (rd_left_next_s != 11'd0);
      avmm_readdata           <= 32'd0;
      avmm_readdatavalid      <= 1'b0;
      avmm_writeresponsevalid <= 1'b0;
      avmm_response           <= RESP_OKAY;
      if (rd_acc_s) begin
        avmm_readdatavalid <= 1'b1;
        if (bc_one_s) begin
          avmm_readdata <= rd_data_s;
          avmm_response <= rd_err_s ? RESP_SLVERR : RESP_OKAY;
        end else begin
          avmm_response <= RESP_SLVERR;
        end
      end else if (rd_left_r != 11'd0) begin
        avmm_readdatavalid <= 1'b1;
        avmm_response      <= RESP_SLVERR;
      end else if (wr_acc_s) begin
        avmm_writeresponsevalid <= 1'b1;
        if ((wr_left_r == 11'd0) && bc_one_s) begin
          avmm_response <= wr_err_s ? RESP_SLVERR : RESP_OKAY;
          if (wr_sel_s && (avmm_byteenable != 4'h0)) begin
            sel_r <= clamp_sel(avmm_writedata);
          end
        end else begin
          avmm_response <= RESP_SLVERR;
        end
      end
    end
  end

endmodule

// File: rtl/dvbs2x_symb_rate_divider_avmm.sv
// -----------------------------------------------------------------------------
// dvbs2x_symb_rate_divider_avmm
// Symbol-rate divider: each accepted input symbol is held and emitted N times
// on the output stream, N = DIV_RATIOS[active_sel]. The selection is set via
// Avalon-MM and applied only at a symbol boundary.
// Ports:
//   clk, sreset_n              - single clock, synchronous active-low reset
//   avmm_*                     - Avalon-MM register slave
//   axis_in_*                  - input symbols, I in [31:16], Q in [15:0]
//   axis_out_*                 - output samples
// -----------------------------------------------------------------------------
module dvbs2x_symb_rate_divider_avmm
  import dvbs2x_symb_rate_divider_pkg::*;
#(
  parameter int unsigned MODULE_ID      = 32'd10,
  parameter int unsigned MODULE_VERSION = 32'd1,
  parameter rate_table_t DIV_RATIOS     = DIV_RATIOS_DEF,
  parameter rate_table_t SYMB_RATE_MSPS = SYMB_RATE_MSPS_DEF
) (
  input  logic        clk,
  input  logic        sreset_n,
  input  logic [14:0] avmm_address,
  input  logic        avmm_read,
  input  logic        avmm_write,
  input  logic [31:0] avmm_writedata,
  input  logic [3:0]  avmm_byteenable,
  input  logic [10:0] avmm_burstcount,
  output logic [31:0] avmm_readdata,
  output logic        avmm_readdatavalid,
  output logic        avmm_writeresponsevalid,
  output logic [1:0]  avmm_response,
  output logic        avmm_waitrequest,
  input  logic [31:0] axis_in_tdata,
  input  logic        axis_in_tvalid,
  input  logic        axis_in_tlast,
  output logic        axis_in_tready,
  output logic [31:0] axis_out_tdata,
  output logic        axis_out_tvalid,
  output logic        axis_out_tlast,
  input  logic        axis_out_tready
);

  logic             run_r;
  logic [31:0]      hold_data_r;
  logic             hold_valid_r;
  logic             hold_last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [SEL_W-1:0] active_sel_r;

  logic [SEL_W-1:0] sel_s;
  logic [CNT_W-1:0] n_minus1_s;
  logic             last_rep_s;
  logic             out_hs_s;
  logic             in_ready_s;
  logic             in_hs_s;
  logic [CNT_W-1:0] cnt_next_s;

  dvbs2x_symb_rate_divider_regs #(
    .MODULE_ID      (MODULE_ID),
    .MODULE_VERSION (MODULE_VERSION),
    .SYMB_RATE_MSPS (SYMB_RATE_MSPS)
  ) u_regs (
    .clk                     (clk),
    .sreset_n                (sreset_n),
    .init_done               (run_r),
    .active_sel              (active_sel_r),
    .sel                     (sel_s),
    .avmm_address            (avmm_address),
    .avmm_read               (avmm_read),
    .avmm_write              (avmm_write),
    .avmm_writedata          (avmm_writedata),
    .avmm_byteenable         (avmm_byteenable),
    .avmm_burstcount         (avmm_burstcount),
    .avmm_readdata           (avmm_readdata),
    .avmm_readdatavalid      (avmm_readdatavalid),
    .avmm_writeresponsevalid (avmm_writeresponsevalid),
    .avmm_response           (avmm_response),
    .avmm_waitrequest        (avmm_waitrequest)
  );

  assign axis_out_tvalid = hold_valid_r;
  assign axis_out_tdata  = hold_data_r;
  assign axis_out_tlast  = hold_last_r && last_rep_s;
  assign axis_in_tready  = in_ready_s;

  // Repeat counter control and stream handshakes.
  always_comb begin
    n_minus1_s = CNT_W'(DIV_RATIOS[active_sel_r] - 32'd1);
    last_rep_s = (cnt_r == n_minus1_s);
    out_hs_s   = hold_valid_r && axis_out_tready;
    // Refill in the same cycle the last repeat leaves, so symbols flow
    // back-to-back; run_r keeps tready low while in reset.
    in_ready_s = run_r && (!hold_valid_r || (axis_out_tready && last_rep_s));
    in_hs_s    = axis_in_tvalid && in_ready_s;
    if (out_hs_s) begin
      if (last_rep_s) begin
        cnt_next_s = {CNT_W{1'b0}};
      end else begin
        cnt_next_s = cnt_r + CNT_W'(1'b1);
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Hold register, repeat counter and boundary-aligned rate selection.
  always_ff @(posedge clk) begin
    if (!sreset_n) begin
      run_r        <= 1'b0;
      hold_data_r  <= 32'd0;
      hold_valid_r <= 1'b0;
      hold_last_r  <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      active_sel_r <= {SEL_W{1'b0}};
    end else begin
      run_r <= 1'b1;
      cnt_r <= cnt_next_s;
      // With cnt at 0 next cycle no repeat of the held symbol has been
      // emitted, so a new N cannot truncate or extend it.
      if (cnt_next_s == {CNT_W{1'b0}}) begin
        active_sel_r <= sel_s;
      end else begin
        active_sel_r <= active_sel_r;
      end
      if (in_hs_s) begin
        hold_data_r  <= axis_in_tdata;
        hold_last_r  <= axis_in_tlast;
        hold_valid_r <= 1'b1;
      end else if (out_hs_s && last_rep_s) begin
        hold_valid_r <= 1'b0;
      end else begin
        hold_valid_r <= hold_valid_r;
      end
    end
  end

endmodule

// File: tb/tb_dvbs2x_symb_rate_divider_avmm.sv
module tb_dvbs2x_symb_rate_divider_avmm;

  localparam int W_ID    = 0;
  localparam int W_VER   = 1;
  localparam int W_STATE = 2;
  localparam int W_SEL   = 3;
  localparam int W_RATE  = 4;
  localparam int W_TOTAL = 5;

  // Reference tables straight from the rate plan.
  int unsigned div_tab  [4] = '{1, 2, 4, 8};
  int unsigned rate_tab [4] = '{100, 50, 25, 12};

  logic        clk = 1'b0;
  logic        sreset_n;
  logic [14:0] avmm_address;
  logic        avmm_read, avmm_write;
  logic [31:0] avmm_writedata;
  logic [3:0]  avmm_byteenable;
  logic [10:0] avmm_burstcount;
  logic [31:0] avmm_readdata;
  logic        avmm_readdatavalid, avmm_writeresponsevalid, avmm_waitrequest;
  logic [1:0]  avmm_response;
  logic [31:0] axis_in_tdata, axis_out_tdata;
  logic        axis_in_tvalid, axis_in_tlast, axis_in_tready;
  logic        axis_out_tvalid, axis_out_tlast, axis_out_tready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct packed { logic [1:0] resp; logic [31:0] data; } rsp_t;
  typedef struct packed { logic l; logic [31:0] d; } beat_t;
  rsp_t  rsp_q[$];
  int    rsp_lat;
  beat_t send_q[$], src_q[$], acc_q[$], cap_q[$];
  bit    presenting = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dvbs2x_symb_rate_divider_avmm dut (
    .clk(clk), .sreset_n(sreset_n),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
    .avmm_burstcount(avmm_burstcount), .avmm_readdata(avmm_readdata),
    .avmm_readdatavalid(avmm_readdatavalid),
    .avmm_writeresponsevalid(avmm_writeresponsevalid),
    .avmm_response(avmm_response), .avmm_waitrequest(avmm_waitrequest),
    .axis_in_tdata(axis_in_tdata), .axis_in_tvalid(axis_in_tvalid),
    .axis_in_tlast(axis_in_tlast), .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tvalid(axis_out_tvalid),
    .axis_out_tlast(axis_out_tlast), .axis_out_tready(axis_out_tready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sample_rsp(input bit is_wr, input int acc_cyc);
    if ((is_wr && avmm_writeresponsevalid) || (!is_wr && avmm_readdatavalid)) begin
      if (rsp_q.size() == 0) rsp_lat = cyc - acc_cyc + 1;
      rsp_q.push_back({avmm_response, avmm_readdata});
    end
  endtask

  // Issue nbeats command beats and collect nresp responses (bounded waits).
  task automatic avmm_xfer(input bit is_wr, input int word, input logic [31:0] wdata,
                           input logic [10:0] bc, input int nbeats, input int nresp);
    int acc_cyc;
    int w;
    rsp_q.delete();
    rsp_lat = -1;
    acc_cyc = cyc;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      sample_rsp(is_wr, acc_cyc);
      avmm_address    = 15'(word * 4);
      avmm_writedata  = wdata;
      avmm_burstcount = bc;
      avmm_byteenable = 4'hf;
      avmm_write      = is_wr;
      avmm_read       = !is_wr;
      w = 0;
      while (avmm_waitrequest && w < 50) begin
        @(negedge clk);
        sample_rsp(is_wr, acc_cyc);
        w++;
      end
      if (avmm_waitrequest) check("waitrequest_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      if (b == 0) acc_cyc = cyc;
    end
    @(negedge clk);
    avmm_read  = 1'b0;
    avmm_write = 1'b0;
    sample_rsp(is_wr, acc_cyc);
    w = 0;
    while (rsp_q.size() < nresp && w < 50) begin
      @(negedge clk);
      sample_rsp(is_wr, acc_cyc);
      w++;
    end
    check(is_wr ? "wr_rsp_count" : "rd_rsp_count", 64'(rsp_q.size()), 64'(nresp));
  endtask

  task automatic reg_read(input int word, output logic [31:0] data, output logic [1:0] resp);
    avmm_xfer(1'b0, word, 32'd0, 11'd1, 1, 1);
    check("rd_latency", 64'(rsp_lat), 64'd1);
    if (rsp_q.size() > 0) begin
      data = rsp_q[0].data;
      resp = rsp_q[0].resp;
    end else begin
      data = 32'hdeadbeef;
      resp = 2'b11;
    end
  endtask

  task automatic reg_write(input int word, input logic [31:0] data, output logic [1:0] resp);
    avmm_xfer(1'b1, word, data, 11'd1, 1, 1);
    check("wr_latency", 64'(rsp_lat), 64'd1);
    resp = (rsp_q.size() > 0) ? rsp_q[0].resp : 2'b11;
  endtask

  // One clock of stream activity: drive, settle, then record handshakes.
  task automatic step(input bit rdy, input int vpct);
    @(negedge clk);
    axis_out_tready = rdy;
    if (!presenting) begin
      if (send_q.size() > 0 && int'($urandom_range(99)) < vpct) begin
        axis_in_tdata  = send_q[0].d;
        axis_in_tlast  = send_q[0].l;
        axis_in_tvalid = 1'b1;
        presenting     = 1'b1;
      end else begin
        axis_in_tvalid = 1'b0;
      end
    end
    #1;
    if (axis_in_tvalid && axis_in_tready) begin
      acc_q.push_back(send_q.pop_front());
      presenting = 1'b0;
    end
    if (axis_out_tvalid && axis_out_tready) cap_q.push_back({axis_out_tlast, axis_out_tdata});
  endtask

  // Expected stream: each source symbol n times, tlast only on the final copy.
  task automatic compare_stream(input string tag, input int n);
    int idx = 0;
    int e0 = errors;
    check({tag, "_count"}, 64'(cap_q.size()), 64'(src_q.size() * n));
    for (int i = 0; i < src_q.size() && errors == e0; i++) begin
      for (int k = 0; k < n && errors == e0; k++) begin
        if (idx < cap_q.size())
          check(tag, 64'(cap_q[idx]), 64'({src_q[i].l && (k == n - 1), src_q[i].d}));
        idx++;
      end
    end
  endtask

  task automatic run_stream(input string tag, input int nsym, input int n,
                            input int rpct, input int vpct, output int steps);
    int limit = nsym * n * 6 + 100;
    send_q.delete(); src_q.delete(); acc_q.delete(); cap_q.delete();
    for (int i = 0; i < nsym; i++) send_q.push_back({($urandom_range(3) == 0), $urandom});
    src_q = send_q;
    steps = 0;
    while ((send_q.size() > 0 || cap_q.size() < nsym * n) && steps < limit) begin
      step(int'($urandom_range(99)) < rpct, vpct);
      steps++;
    end
    for (int i = 0; i < 12; i++) step(1'b1, 0);
    compare_stream(tag, n);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          steps;
    int          exp_sel;
    int          polls;

    sreset_n = 1'b0;
    avmm_address = 15'd0; avmm_read = 1'b0; avmm_write = 1'b0;
    avmm_writedata = 32'd0; avmm_byteenable = 4'h0; avmm_burstcount = 11'd1;
    axis_in_tdata = 32'd0; axis_in_tvalid = 1'b0; axis_in_tlast = 1'b0;
    axis_out_tready = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_waitrequest", 64'(avmm_waitrequest), 64'd1);
    check("rst_in_tready", 64'(axis_in_tready), 64'd0);
    check("rst_out_tvalid", 64'(axis_out_tvalid), 64'd0);
    check("rst_rdv", 64'(avmm_readdatavalid), 64'd0);
    check("rst_wrv", 64'(avmm_writeresponsevalid), 64'd0);
    sreset_n = 1'b1;

    // Bring-up: poll initdone, then the reset register contents.
    polls = 0;
    d = 32'd0;
    while (polls < 10) begin
      reg_read(W_STATE, d, r);
      polls++;
      if (d[0]) break;
    end
    check("initdone", 64'(d[0]), 64'd1);
    reg_read(W_ID, d, r);   check("id", 64'(d), 64'd10);
    reg_read(W_VER, d, r);  check("version", 64'(d), 64'd1);
    reg_read(W_SEL, d, r);  check("sel_reset", 64'(d), 64'd0);
    reg_read(W_RATE, d, r); check("rate_reset", 64'(d), 64'(rate_tab[0]));

    // N=1: one symbol per clock with continuous valid/ready.
    run_stream("n1_stream", 20, int'(div_tab[0]), 100, 100, steps);
    check("n1_throughput", 64'(steps <= 22), 64'd1);

    // Selection 2.
    reg_write(W_SEL, 32'd2, r); check("wr_sel2_resp", 64'(r), 64'd0);
    reg_read(W_SEL, d, r);      check("sel2_rb", 64'(d), 64'd2);
    reg_read(W_RATE, d, r);     check("rate2", 64'(d), 64'(rate_tab[2]));
    run_stream("n4_stream", 30, int'(div_tab[2]), 70, 60, steps);

    // Out-of-range selection saturates.
    reg_write(W_SEL, 32'd7, r); check("wr_sel7_resp", 64'(r), 64'd0);
    exp_sel = (7 >= 4) ? 3 : 7;
    reg_read(W_SEL, d, r);      check("sel7_rb", 64'(d), 64'(exp_sel));
    reg_read(W_RATE, d, r);     check("rate7", 64'(d), 64'(rate_tab[exp_sel]));
    run_stream("n8_stream", 10, int'(div_tab[exp_sel]), 80, 80, steps);

    // Change selection 1 -> 3 while the first symbol is mid-repeat.
    reg_write(W_SEL, 32'd1, r);
    send_q.delete(); acc_q.delete(); cap_q.delete();
    send_q.push_back({1'b0, 32'h1111_aaaa});
    send_q.push_back({1'b1, 32'h2222_bbbb});
    src_q = send_q;
    for (int i = 0; i < 10 && acc_q.size() == 0; i++) step(1'b0, 100);
    step(1'b1, 100);
    step(1'b0, 100);
    reg_write(W_SEL, 32'd3, r);
    for (int i = 0; i < 60 && cap_q.size() < 10; i++) step(1'b1, 100);
    for (int i = 0; i < 12; i++) step(1'b1, 0);
    check("mid_count", 64'(cap_q.size()), 64'd10);
    for (int i = 0; i < 10 && i < cap_q.size(); i++)
      check("mid_beat", 64'(cap_q[i]),
            64'((i < 2) ? {1'b0, 32'h1111_aaaa} : {(i == 9), 32'h2222_bbbb}));

    // Long run with random backpressure at N=4.
    reg_write(W_SEL, 32'd2, r);
    run_stream("bp_stream", 500, int'(div_tab[2]), 55, 75, steps);

    // Error handling and read-only registers.
    reg_read(W_TOTAL + 5, d, r);
    check("oob_rd_resp", 64'(r), 64'd2);
    check("oob_rd_data", 64'(d), 64'd0);
    reg_write(W_RATE, 32'd99, r); check("ro_wr_resp", 64'(r), 64'd0);
    reg_read(W_RATE, d, r);       check("ro_rate_kept", 64'(d), 64'(rate_tab[2]));
    reg_write(W_ID, 32'd55, r);   check("id_wr_resp", 64'(r), 64'd0);
    reg_read(W_ID, d, r);         check("id_kept", 64'(d), 64'd10);
    reg_write(W_TOTAL + 9, 32'd1, r); check("oob_wr_resp", 64'(r), 64'd2);
    reg_read(W_SEL, d, r);        check("sel_after_oob", 64'(d), 64'd2);

    // Bursts are rejected beat by beat.
    avmm_xfer(1'b0, W_SEL, 32'd0, 11'd3, 1, 3);
    for (int i = 0; i < rsp_q.size(); i++) begin
      check("brd_resp", 64'(rsp_q[i].resp), 64'd2);
      check("brd_data", 64'(rsp_q[i].data), 64'd0);
    end
    avmm_xfer(1'b1, W_SEL, 32'd1, 11'd2, 2, 2);
    for (int i = 0; i < rsp_q.size(); i++) check("bwr_resp", 64'(rsp_q[i].resp), 64'd2);
    reg_read(W_SEL, d, r);        check("sel_after_burst", 64'(d), 64'd2);

    // Reset while a symbol is held discards it.
    send_q.delete(); acc_q.delete(); cap_q.delete();
    send_q.push_back({1'b0, 32'h3333_cccc});
    for (int i = 0; i < 10 && acc_q.size() == 0; i++) step(1'b0, 100);
    @(negedge clk);
    axis_in_tvalid = 1'b0;
    sreset_n = 1'b0;
    repeat (2) @(negedge clk);
    sreset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_discard_tvalid", 64'(axis_out_tvalid), 64'd0);
    reg_read(W_SEL, d, r);        check("sel_after_rst", 64'(d), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
